// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability-counter debounce FSM,
// registered press/release/long-press strobes and a press-driven toggle for an LED.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 50000000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic btn_toggle
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int LW = $clog2(LONG_CYCLES) + 1;
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);
   localparam logic [LW-1:0] LONG_PRE = LW'(LONG_CYCLES - 1);
   // Raw pin level that means "released"; the synchronizer idles here.
   localparam logic IDLE_PIN = BTN_ACTIVE_LOW;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   logic          run;
   logic          sync1, sync2;
   logic          s;
   state_t        state_q, state_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] hold_q, hold_d;
   logic          level_d, press_d, release_d, long_d, toggle_d;
   logic          accept;

   // Reset asserts asynchronously but releases on a clock edge: run rises on the
   // first edge after rst_n, so the second edge is the first functional one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         run <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= IDLE_PIN;
         sync2 <= IDLE_PIN;
      end else if (!run) begin
         sync1 <= IDLE_PIN;
         sync2 <= IDLE_PIN;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   assign s = sync2 ^ BTN_ACTIVE_LOW;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      state_d   = state_q;
      cnt_d     = '0;
      hold_d    = hold_q;
      level_d   = btn_level;
      toggle_d  = btn_toggle;
      accept    = 1'b0;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;

      if (s != btn_level) begin
         if (cnt_q == DB_LAST) begin
            accept = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      unique case (state_q)
         RELEASED:     if (s) state_d = PRESS_WAIT;
         PRESS_WAIT: begin
            if (accept)  state_d = PRESSED;
            else if (!s) state_d = RELEASED;
         end
         PRESSED:      if (!s) state_d = RELEASE_WAIT;
         RELEASE_WAIT: begin
            if (accept) state_d = RELEASED;
            else if (s) state_d = PRESSED;
         end
         default:      state_d = RELEASED;
      endcase

      if (accept) begin
         level_d   = s;
         press_d   = s;
         release_d = !s;
         toggle_d  = btn_toggle ^ s;
      end

      // Hold counter saturates, so long_pulse can only fire once per press.
      if (!btn_level) begin
         hold_d = '0;
      end else if (hold_q != LONG_MAX) begin
         hold_d = hold_q + 1'b1;
         long_d = (hold_q == LONG_PRE);
      end

      if (!run) begin
         state_d   = RELEASED;
         cnt_d     = '0;
         hold_d    = '0;
         level_d   = 1'b0;
         toggle_d  = 1'b0;
         press_d   = 1'b0;
         release_d = 1'b0;
         long_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RELEASED;
         cnt_q         <= '0;
         hold_q        <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         btn_toggle    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         hold_q        <= hold_d;
         btn_level     <= level_d;
         press_pulse   <= press_d;
         release_pulse <= release_d;
         long_pulse    <= long_d;
         btn_toggle    <= toggle_d;
      end
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10, active-low pin.
module tb_btn_debounce;

   logic clk = 1'b0;
   logic rst_n;
   logic btn;
   logic btn_level, press_pulse, release_pulse, long_pulse, btn_toggle;

   int total = 0;
   int bad = 0;
   int n_press = 0;
   int n_release = 0;
   int n_long = 0;
   int n_both = 0;
   int p0, r0, l0;
   logic exp_toggle;

   btn_debounce #(
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES    (10),
      .BTN_ACTIVE_LOW (1'b1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn          (btn),
      .btn_level    (btn_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse),
      .btn_toggle   (btn_toggle)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled shortly after each rising edge.
   always begin
      @(posedge clk);
      #2;
      if (press_pulse)                  n_press++;
      if (release_pulse)                n_release++;
      if (long_pulse)                   n_long++;
      if (press_pulse && release_pulse) n_both++;
   end

   task automatic edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_level"},   btn_level,     1'b0);
      check({tag, "_press"},   press_pulse,   1'b0);
      check({tag, "_release"}, release_pulse, 1'b0);
      check({tag, "_long"},    long_pulse,    1'b0);
      check({tag, "_toggle"},  btn_toggle,    1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      btn   = 1'b1;
      exp_toggle = 1'b0;
      edges(3);
      check_all_zero("rst");
      rst_n = 1'b1;
      edges(5);
      check("idle_level", btn_level, 1'b0);

      // Clean press held long enough for a long press, then released.
      btn = 1'b0;
      edges(5);
      check("press_e5_level", btn_level, 1'b0);
      check("press_e5_pulse", press_pulse, 1'b0);
      edges(1);
      exp_toggle = ~exp_toggle;
      check("press_e6_level",  btn_level,   1'b1);
      check("press_e6_pulse",  press_pulse, 1'b1);
      check("press_e6_toggle", btn_toggle,  exp_toggle);
      edges(1);
      check("press_e7_pulse", press_pulse, 1'b0);
      edges(8);
      check("long_e15", long_pulse, 1'b0);
      edges(1);
      check("long_e16", long_pulse, 1'b1);
      edges(1);
      check("long_e17", long_pulse, 1'b0);
      edges(3);
      btn = 1'b1;
      edges(5);
      check("rel_r5_level", btn_level, 1'b1);
      check("rel_r5_pulse", release_pulse, 1'b0);
      edges(1);
      check("rel_r6_level",  btn_level,     1'b0);
      check("rel_r6_pulse",  release_pulse, 1'b1);
      check("rel_r6_toggle", btn_toggle,    exp_toggle);
      edges(1);
      check("rel_r7_pulse", release_pulse, 1'b0);
      check_int("hold_press_cnt",   n_press,   1);
      check_int("hold_long_cnt",    n_long,    1);
      check_int("hold_release_cnt", n_release, 1);

      // Bounce: 3 low, 1 high, 3 low samples never reach four stable ones.
      edges(4);
      p0 = n_press; r0 = n_release;
      btn = 1'b0; edges(3);
      btn = 1'b1; edges(1);
      btn = 1'b0; edges(3);
      check("bounce_mid_level", btn_level, 1'b0);
      btn = 1'b1; edges(10);
      check("bounce_level",  btn_level,  1'b0);
      check("bounce_toggle", btn_toggle, exp_toggle);
      check_int("bounce_press_cnt",   n_press - p0,   0);
      check_int("bounce_release_cnt", n_release - r0, 0);

      // Two full press/release cycles.
      p0 = n_press; r0 = n_release; l0 = n_long;
      for (int i = 0; i < 2; i++) begin
         btn = 1'b0;
         edges(6);
         exp_toggle = ~exp_toggle;
         check("cyc_level_hi", btn_level,  1'b1);
         check("cyc_toggle",   btn_toggle, exp_toggle);
         edges(3);
         btn = 1'b1;
         edges(6);
         check("cyc_level_lo", btn_level,  1'b0);
         check("cyc_toggle_r", btn_toggle, exp_toggle);
         edges(2);
      end
      check_int("cyc_press_cnt",   n_press - p0,   2);
      check_int("cyc_release_cnt", n_release - r0, 2);
      check_int("cyc_long_cnt",    n_long - l0,    0);

      // Reset mid-press, button still held afterwards.
      btn = 1'b0;
      edges(8);
      check("prer_level", btn_level, 1'b1);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      edges(3);
      check_all_zero("midrst_hold");
      p0 = n_press;
      rst_n = 1'b1;
      edges(6);
      check("post_e6_level", btn_level,   1'b0);
      check("post_e6_press", press_pulse, 1'b0);
      check_int("post_e6_cnt", n_press - p0, 0);
      edges(1);
      check("post_e7_level",  btn_level,   1'b1);
      check("post_e7_press",  press_pulse, 1'b1);
      check("post_e7_toggle", btn_toggle,  1'b1);
      edges(1);
      check("post_e8_press", press_pulse, 1'b0);
      check_int("both_high_cnt", n_both, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive stable synchronized samples needed to accept a new level (range 2..2^24).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 50000000, meaning the cycles the debounced level must stay pressed before a long-press pulse (must exceed DEBOUNCE_CYCLES).
REQ-003 The block SHALL have parameter BTN_ACTIVE_LOW, default 1, meaning 1 = raw pin low means pressed and 0 = raw pin high means pressed.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port btn, input, 1 bit, the raw asynchronous push-button pin.
REQ-007 The block SHALL have port btn_level, output, 1 bit, the debounced pressed state (1 = pressed).
REQ-008 The block SHALL have port press_pulse, output, 1 bit, a one-cycle strobe on an accepted press.
REQ-009 The block SHALL have port release_pulse, output, 1 bit, a one-cycle strobe on an accepted release.
REQ-010 The block SHALL have port long_pulse, output, 1 bit, a one-cycle strobe when a press has lasted LONG_CYCLES.
REQ-011 The block SHALL have port btn_toggle, output, 1 bit, which inverts on every press_pulse and directly drives an LED.

Function
REQ-012 btn SHALL pass through a two-flop synchronizer, then be polarity-normalized per BTN_ACTIVE_LOW to give s (1 = pressed); no other logic samples btn.
REQ-013 Stability counter: it SHALL reset to 0 on any edge where s equals btn_level, and increment on each edge where s differs from btn_level.
REQ-014 When s differs from btn_level and the counter equals DEBOUNCE_CYCLES-1, the next edge SHALL set btn_level to s and clear the counter. A step held stable therefore appears on btn_level 2+DEBOUNCE_CYCLES edges after it is applied.
REQ-015 A glitch or bounce shorter than DEBOUNCE_CYCLES samples SHALL leave btn_level unchanged and SHALL produce no pulses.
REQ-016 The state machine SHALL have these states and transitions:
- RELEASED -> PRESS_WAIT when s=1.
- PRESS_WAIT -> RELEASED when s=0.
- PRESS_WAIT -> PRESSED on acceptance.
- PRESSED -> RELEASE_WAIT when s=0.
- RELEASE_WAIT -> PRESSED when s=1.
- RELEASE_WAIT -> RELEASED on acceptance.
REQ-017 press_pulse and release_pulse SHALL be registered and high for exactly the one cycle in which btn_level has just changed 0->1 or 1->0 respectively; they are never both high.
REQ-018 Hold counter: it SHALL clear when btn_level is 0, increment each cycle while btn_level is 1, and saturate at LONG_CYCLES.
REQ-019 long_pulse SHALL be high for exactly one cycle, the cycle the hold counter first reaches LONG_CYCLES, and SHALL not repeat until a release and a new press occur.
REQ-020 btn_toggle SHALL invert on the edge where press_pulse is registered high; releases and long presses do not affect it.
REQ-021 Counter widths SHALL be $clog2 of the parameter plus 1; the counters SHALL never wrap.

Reset
REQ-022 While rst_n=0, regardless of clk, the block SHALL hold:
- btn_level=0, press_pulse=0, release_pulse=0, long_pulse=0, btn_toggle=0.
- Both synchronizer flops at the released level.
- Both counters at 0 and the state at RELEASED.
REQ-023 Reset deassertion SHALL be synchronized to clk internally. The first functional edge is the second rising clk edge after rst_n rises.
REQ-024 Reset asserted mid-press SHALL abort with no pending pulse. A button still held after reset needs a full DEBOUNCE_CYCLES qualification before press_pulse.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, BTN_ACTIVE_LOW=1)
REQ-025 Clean press: btn 1->0 held -> btn_level=1 and press_pulse=1 exactly 6 edges later for 1 cycle, and btn_toggle=1.
REQ-026 Bounce: btn low for 3 edges, high for 1, low for 3, then high -> no change on btn_level, press_pulse or btn_toggle.
REQ-027 Long hold: btn held low for 20 edges -> press_pulse once, then long_pulse once 10 edges later, with no repeat; release -> release_pulse once, 6 edges after release.
REQ-028 Two full press/release cycles -> btn_toggle goes 0->1->0, with exactly 2 press_pulse and 2 release_pulse.
REQ-029 rst_n pulled low while pressed and released after 3 cycles, with btn held low -> all outputs 0 during reset. press_pulse occurs only after 2+4 further functional edges.
